// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the key schedule and the cipher datapath:
// S-box, xtime, round-key type and key-schedule FSM states.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_t;

  // Forward S-box, one 16-byte row per high nibble of the input byte.
  localparam logic [0:15][127:0] SBOX_ROWS = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROWS[b[7:4]];
    return row[8*(15 - int'(b[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: derives the next round key from the
// previous one and the current round constant. Purely combinational.
module aes_key_round
  import aes_pkg::*;
(
  input  round_key_t  prev_key,
  input  logic [7:0]  rcon,
  output round_key_t  next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] w4, w5, w6, w7;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  // Each word chains off the previous one, so the path is one S-box plus the XOR ripple.
  assign w4 = w0 ^ sub ^ {rcon, 24'h000000};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key scheduler: expands one round key per cycle through a
// single shared round stage, buffers all round keys and serves them by index.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_in,
  input  logic          key_load,
  output logic          key_ready,
  output logic          busy,
  output logic          keys_valid,
  input  logic          rk_rd_en,
  input  logic [3:0]    rk_rd_idx,
  output logic [KW-1:0] rk_out,
  output logic          rk_out_valid,
  output logic          rk_rd_err
);

  ks_state_t     state, state_next;
  logic [3:0]    ctr;
  logic [7:0]    rcon;
  logic [KW-1:0] key_buf [0:NR];
  logic [KW-1:0] round_in, round_out;
  logic          load_accept;
  logic          last_round;
  logic          rd_ok;

  assign load_accept = key_load && key_ready;
  assign last_round  = (ctr == 4'(NR));
  // A load in the same cycle invalidates the buffer, so it wins over a read.
  assign rd_ok = rk_rd_en && keys_valid && !load_accept && (rk_rd_idx <= 4'(NR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_load) state_next = ST_EXPAND;
      end
      ST_EXPAND: begin
        busy = 1'b1;
        if (last_round) state_next = ST_DONE;
      end
      ST_DONE: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
        if (key_load) state_next = ST_EXPAND;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr  <= 4'd0;
      rcon <= 8'h01;
    end else if (load_accept) begin
      ctr  <= 4'd1;
      rcon <= 8'h01;
    end else if (busy) begin
      ctr  <= ctr + 4'd1;
      rcon <= xtime(rcon);
    end
  end

  assign round_in = key_buf[ctr - 4'd1];

  aes_key_round u_round (
    .prev_key (round_in),
    .rcon     (rcon),
    .next_key (round_out)
  );

  // Buffer contents are deliberately left unreset; keys_valid guards every read.
  always_ff @(posedge clk) begin
    if (load_accept)  key_buf[0]   <= key_in;
    else if (busy)    key_buf[ctr] <= round_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out       <= '0;
      rk_out_valid <= 1'b0;
      rk_rd_err    <= 1'b0;
    end else begin
      rk_out_valid <= rd_ok;
      rk_rd_err    <= rk_rd_en && !rd_ok;
      if (rd_ok) rk_out <= key_buf[rk_rd_idx];
    end
  end

endmodule
